sys_array_result_ctrl: RTL
==========================

# sys_array_result_ctrl

Single-clock sequencer and result viewer for the systolic-array fetcher. It drives the fetcher's `load_params` / `start_comp` handshake and captures the full result matrix into a local buffer when `ready` rises. The buffer is then shown element by element on `NUM_HEX` seven-segment digits, stepped manually or by an internal tick-enable. It generalises the previous wrapper:
- the result matrix may be rectangular;
- the digit count is parametrised;
- the derived clock is replaced by a tick-enable;
- manual/auto browsing, element-index outputs and restart-on-demand are added.

## Interface
- `DATA_WIDTH`, 8, operand width; each result element is 2*DATA_WIDTH bits.
- `RES_ROWS`, 5, result matrix rows.
- `RES_COLS`, 5, result matrix columns.
- `NUM_HEX`, 4, number of seven-segment digits driven.
- `TICK_DIV`, 25, auto-advance period is 2^TICK_DIV clk cycles.
- Derived: `RW = max(1, $clog2(RES_ROWS))`, `CW = max(1, $clog2(RES_COLS))`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  single-cycle request to start a computation.
- `step`  in  1  single-cycle manual advance (already synchronised/debounced).
- `auto_mode`  in  1  1 = advance on tick, 0 = advance on `step` only.
- `load_params`  out  1  to fetcher.
- `start_comp`  out  1  to fetcher.
- `ready`  in  1  from fetcher; high when `out_data` is valid.
- `out_data`  in  RES_ROWS*RES_COLS*2*DATA_WIDTH  packed `[0:RES_ROWS-1][0:RES_COLS-1][2*DATA_WIDTH-1:0]`.
- `hex_connect`  out  8*NUM_HEX  digit i on bits `[8*i +: 8]`.
- `elem_row`  out  RW  row of the displayed element.
- `elem_col`  out  CW  column of the displayed element.
- `showing`  out  1  high while in SHOW.
- `busy`  out  1  high in LOAD, COMP or CAPTURE.

## Operation
- **FSM states:**
  - IDLE: `go` → LOAD.
  - LOAD: `load_params`=1 for exactly one cycle → COMP.
  - COMP: `start_comp`=1 held; `ready`=1 → CAPTURE.
  - CAPTURE: buffer <= `out_data` → SHOW.
  - SHOW: `go` → LOAD; otherwise stay.
- `go` in LOAD, COMP or CAPTURE is ignored. `ready` outside COMP is ignored.
- **Entering SHOW:**
  - index = (0,0);
  - tick counter = 0.
- **Advance:**
  - Row-major order: col+1; at col = RES_COLS-1, col→0 and row+1; at (RES_ROWS-1, RES_COLS-1), wrap to (0,0).
  - Advance occurs in SHOW only, on `step`, or on tick when `auto_mode`=1.
  - `step` and tick in the same cycle advance the index once.
- **Tick counter:**
  - Counts only in SHOW with `auto_mode`=1; holds otherwise.
  - Reaching 2^TICK_DIV-1 produces a tick and wraps to 0.
  - Any `step` clears it to 0.
- **Display value:**
  - Register `disp <= buffer[elem_row][elem_col]` every cycle in SHOW.
  - Digit i shows nibble i of `disp` via `seg7_tohex`.
  - Digits with 4*i ≥ 2*DATA_WIDTH show nibble 0.
- The buffer changes only in CAPTURE. Later changes on `out_data` do not affect the display.
- Leaving SHOW for LOAD (restart): `showing` drops; the index and `disp` hold their values until the next SHOW entry.
- **Reset values** (while `reset_n`=0 at an edge):
  - state = IDLE;
  - `load_params`, `start_comp`, `showing`, `busy` = 0;
  - index = (0,0), tick counter = 0;
  - buffer = 0, `disp` = 0, so every digit shows "0".
- Reset has priority over every event, including mid-COMP. The fetcher sees `start_comp`=0 after that edge.

## Timing
- `go` sampled at edge n (IDLE) → `load_params`=1 during cycle n+1.
- `start_comp`=1 from cycle n+2 until the edge on which `ready` is sampled high (edge m).
- CAPTURE during cycle m+1.
- `showing`=1 from cycle m+2.
- `hex_connect` is valid for element (0,0) from cycle m+3.
- All control outputs are registered. Hex lags the index by one cycle.
- Auto period: exactly 2^TICK_DIV cycles between advances with no `step`.

## Structure
- **Package `sys_array_pkg`:**
  - FSM state enum (IDLE, LOAD, COMP, CAPTURE, SHOW);
  - the safe-clog2 helper function used for RW/CW.
- **Sub-module `sys_array_tick_gen`:**
  - parameter TICK_DIV;
  - ports: clk, reset_n, enable, clear, tick.
- **Reused:** `seg7_tohex`, instantiated NUM_HEX times.

## Test plan
1. **Reset:** `reset_n`=0 for 3 cycles → `load_params`, `start_comp`, `showing`, `busy` = 0; all digits show "0"; `elem_row`/`elem_col` = 0.
2. **Basic run:** RES_ROWS=RES_COLS=2, DATA_WIDTH=8. `go` pulse; fetcher model raises `ready` 10 cycles after `start_comp` with 0x0001, 0x00A2, 0x0B03, 0xC004 → `load_params` high for one cycle; `start_comp` held until `ready`; `showing` high 2 cycles after `ready`; hex = 0001.
3. **Manual browsing:** 4 `step` pulses, `auto_mode`=0 → (row,col) = (0,1),(1,0),(1,1),(0,0); hex = 00A2, 0B03, C004, 0001.
4. **Auto browsing:** TICK_DIV=3, `auto_mode`=1 → advance every 8 cycles; a `step` at count 5 advances once and the next advance comes 8 cycles later.
5. **Capture and restart:** change `out_data` during SHOW → display unchanged; `go` in SHOW → `showing` drops next cycle, LOAD pulse, new results shown from (0,0).
6. **Reset mid-operation:** `reset_n`=0 mid-COMP → `start_comp`=0 after that edge, IDLE; a later `ready` produces no capture.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array result controller.
package sys_array_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StComp,
    StCapture,
    StShow
  } state_e;

  // Index width that stays at least one bit for single-row/column matrices.
  function automatic int unsigned safe_clog2(input int unsigned value);
    if (value <= 32'd1) return 32'd1;
    return $clog2(value);
  endfunction

endpackage

// File: rtl/seg7_tohex.sv
// Nibble to seven-segment decoder; active-low segments {dp,g,f,e,d,c,b,a}, dp off.
module seg7_tohex (
  input  logic [3:0] hex_number,
  output logic [7:0] hex_display
);

  always_comb begin
    hex_display = 8'hFF;
    unique case (hex_number)
      4'h0: hex_display = 8'hC0;
      4'h1: hex_display = 8'hF9;
      4'h2: hex_display = 8'hA4;
      4'h3: hex_display = 8'hB0;
      4'h4: hex_display = 8'h99;
      4'h5: hex_display = 8'h92;
      4'h6: hex_display = 8'h82;
      4'h7: hex_display = 8'hF8;
      4'h8: hex_display = 8'h80;
      4'h9: hex_display = 8'h90;
      4'hA: hex_display = 8'h88;
      4'hB: hex_display = 8'h83;
      4'hC: hex_display = 8'hC6;
      4'hD: hex_display = 8'hA1;
      4'hE: hex_display = 8'h86;
      4'hF: hex_display = 8'h8E;
      default: hex_display = 8'hFF;
    endcase
  end

endmodule

// File: rtl/sys_array_tick_gen.sv
// Free-running tick enable: one-cycle pulse every 2^TICK_DIV enabled cycles.
module sys_array_tick_gen #(
  parameter int unsigned TICK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  logic [TICK_DIV-1:0] cnt_q;

  assign tick = enable && (cnt_q == '1);

  // Counter wraps to zero naturally on the tick cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/sys_array_result_ctrl.sv
// Sequences the fetcher load/compute handshake, captures the result matrix and
// browses it element by element on seven-segment digits.
module sys_array_result_ctrl
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RES_ROWS   = 5,
  parameter int unsigned RES_COLS   = 5,
  parameter int unsigned NUM_HEX    = 4,
  parameter int unsigned TICK_DIV   = 25,
  localparam int unsigned RW = safe_clog2(RES_ROWS),
  localparam int unsigned CW = safe_clog2(RES_COLS),
  localparam int unsigned EW = 2 * DATA_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       go,
  input  logic                                       step,
  input  logic                                       auto_mode,
  output logic                                       load_params,
  output logic                                       start_comp,
  input  logic                                       ready,
  input  logic [0:RES_ROWS-1][0:RES_COLS-1][EW-1:0] out_data,
  output logic [8*NUM_HEX-1:0]                       hex_connect,
  output logic [RW-1:0]                              elem_row,
  output logic [CW-1:0]                              elem_col,
  output logic                                       showing,
  output logic                                       busy
);

  state_e state_q, state_d;

  logic [0:RES_ROWS-1][0:RES_COLS-1][EW-1:0] buffer_q;
  logic [EW-1:0]                              disp_q;
  logic [RW-1:0]                              row_q, row_d;
  logic [CW-1:0]                              col_q, col_d;

  logic in_show, show_entry, advance;
  logic tick, tick_en, tick_clr;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (go) state_d = StLoad;
      StLoad:    state_d = StComp;
      StComp:    if (ready) state_d = StCapture;
      StCapture: state_d = StShow;
      StShow:    if (go) state_d = StLoad;
      default:   state_d = StIdle;
    endcase
  end

  assign in_show    = (state_q == StShow);
  assign show_entry = (state_d == StShow) && !in_show;
  assign advance    = in_show && (step || tick);

  assign tick_en  = in_show && auto_mode;
  assign tick_clr = step || show_entry;

  sys_array_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (tick_en),
    .clear  (tick_clr),
    .tick   (tick)
  );

  // Row-major walk with wrap back to (0,0).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (show_entry) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (col_q == CW'(RES_COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(RES_ROWS - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      load_params <= 1'b0;
      start_comp  <= 1'b0;
      showing     <= 1'b0;
      busy        <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      buffer_q    <= '0;
      disp_q      <= '0;
    end else begin
      state_q     <= state_d;
      load_params <= (state_d == StLoad);
      start_comp  <= (state_d == StComp);
      showing     <= (state_d == StShow);
      busy        <= (state_d == StLoad) || (state_d == StComp) || (state_d == StCapture);
      row_q       <= row_d;
      col_q       <= col_d;
      if (state_q == StCapture) buffer_q <= out_data;
      if (in_show) disp_q <= buffer_q[row_q][col_q];
    end
  end

  assign elem_row = row_q;
  assign elem_col = col_q;

  // Digits beyond the element width repeat the low nibble.
  for (genvar i = 0; i < NUM_HEX; i++) begin : g_digit
    logic [3:0] nibble;
    if (4 * i < EW) begin : g_nib
      assign nibble = 4'(disp_q >> (4 * i));
    end else begin : g_low
      assign nibble = 4'(disp_q);
    end
    seg7_tohex u_seg7 (
      .hex_number (nibble),
      .hex_display(hex_connect[8*i +: 8])
    );
  end

endmodule
